// File: rtl/latency_endpoint_fifo.sv
// latency_endpoint_fifo
//   Receiving endpoint of the valid/ready/latency switch protocol. Buffers
//   upstream words in a DEPTH-entry FIFO toward the matching engine and
//   reports a saturating latency estimate (BASE_LATENCY + occupancy) upstream.
//   Optional macro LATENCY_ENDPOINT_STALL_PENALTY_EN adds a saturating
//   stall counter to the estimate so a back-pressuring engine looks slower.
module latency_endpoint_fifo #(
    parameter int DWIDTH              = 16,
    parameter int LATENCY_COUNT_WIDTH = 5,
    parameter int DEPTH               = 8,
    parameter int BASE_LATENCY        = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    input  logic [DWIDTH-1:0]              in_data,
    output logic                           in_ready,
    output logic [LATENCY_COUNT_WIDTH-1:0] in_latency,
    output logic                           out_valid,
    output logic [DWIDTH-1:0]              out_data,
    input  logic                           out_ready
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = LATENCY_COUNT_WIDTH + 2;

    localparam logic [SUM_W-1:0] LAT_MAX  = SUM_W'((1 << LATENCY_COUNT_WIDTH) - 1);
    localparam logic [SUM_W-1:0] BASE_EXT = SUM_W'(BASE_LATENCY);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;

    logic             push;
    logic             pop;
    logic [SUM_W-1:0] stall_ext;
    logic [SUM_W-1:0] lat_sum;

    // Handshake outputs are gated by rst and otherwise depend on registered state only
    assign in_ready  = !rst && (count_q != FULL_CNT);
    assign out_valid = !rst && (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef LATENCY_ENDPOINT_STALL_PENALTY_EN
    logic [LATENCY_COUNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    // Stall counter: clears on pop or when empty, else counts refused heads and saturates
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pop || (count_q == '0)) begin
            stall_cnt_d = '0;
        end else if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + LATENCY_COUNT_WIDTH'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_ext = SUM_W'(stall_cnt_q);
`else
    assign stall_ext = '0;
`endif

    // Latency estimate: widened sum clamped to the field maximum, all ones during reset
    always_comb begin
        lat_sum = BASE_EXT + SUM_W'(count_q) + stall_ext;
        if (rst || (lat_sum > LAT_MAX)) begin
            in_latency = '1;
        end else begin
            in_latency = lat_sum[LATENCY_COUNT_WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_latency_endpoint_fifo.sv
// tb_latency_endpoint_fifo
//   Randomized and directed bench for latency_endpoint_fifo. A queue-based
//   reference model tracks buffered words and the stall count; a second DUT
//   instance with BASE_LATENCY=28 exercises latency saturation.
module tb_latency_endpoint_fifo;

    localparam int DW    = 16;
    localparam int LW    = 5;
    localparam int DEPTH = 8;
    localparam int LMAX  = 31;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic          in_ready,   in_ready_s;
    logic [LW-1:0] in_latency, in_latency_s;
    logic          out_valid,  out_valid_s;
    logic [DW-1:0] out_data,   out_data_s;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model_q[$];
    int            stall_m = 0;

    always #5 clk = ~clk;

    latency_endpoint_fifo #(
        .DWIDTH(DW), .LATENCY_COUNT_WIDTH(LW), .DEPTH(DEPTH), .BASE_LATENCY(1)
    ) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .in_latency(in_latency), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready)
    );

    latency_endpoint_fifo #(
        .DWIDTH(DW), .LATENCY_COUNT_WIDTH(LW), .DEPTH(DEPTH), .BASE_LATENCY(28)
    ) u_dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_s), .in_latency(in_latency_s), .out_valid(out_valid_s),
        .out_data(out_data_s), .out_ready(out_ready)
    );

    function automatic int exp_lat(int base);
        int v;
        if (rst) return LMAX;
        v = base + model_q.size();
`ifdef LATENCY_ENDPOINT_STALL_PENALTY_EN
        v = v + stall_m;
`endif
        return (v > LMAX) ? LMAX : v;
    endfunction

    function automatic logic exp_ready();
        return !rst && (model_q.size() != DEPTH);
    endfunction

    function automatic logic exp_valid();
        return !rst && (model_q.size() != 0);
    endfunction

    // Advance one clock edge, updating the model from the inputs applied at that edge
    task automatic tick();
        int sz;
        bit push, pop;
        sz = model_q.size();
        if (rst) begin
            model_q.delete();
            stall_m = 0;
        end else begin
            pop  = out_ready && (sz > 0);
            push = in_valid && (sz < DEPTH);
            if (pop || sz == 0) stall_m = 0;
            else if (!out_ready && stall_m < LMAX) stall_m++;
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back(in_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 16'hABCD; out_ready = 1'b0;
        #1;
        tick();
        tick();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_latency !== 5'b11111) begin errors++; $display("FAIL reset_latency got=%0d exp=31", in_latency); end
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (in_latency !== 5'b00001) begin errors++; $display("FAIL post_reset_latency got=%0d exp=1", in_latency); end
    endtask

    task automatic test_single_word();
        out_ready = 1'b0; in_valid = 1'b1; in_data = 16'd255;
        tick();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 16'd255) begin errors++; $display("FAIL single_data got=%0d exp=255", out_data); end
        checks++; if (in_latency !== 5'b00010) begin errors++; $display("FAIL single_latency got=%0d exp=2", in_latency); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_pop_valid got=%b exp=0", out_valid); end
        checks++; if (in_latency !== 5'b00001) begin errors++; $display("FAIL single_pop_latency got=%0d exp=1", in_latency); end
    endtask

    task automatic test_full();
        logic [DW-1:0] got[$];
        bool_accept: begin end
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = DW'(i);
            tick();
        end
        in_data = 16'd9;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%b exp=0", in_ready); end
        checks++; if (in_latency !== LW'(exp_lat(1))) begin errors++; $display("FAIL full_latency got=%0d exp=%0d", in_latency, exp_lat(1)); end
`ifndef LATENCY_ENDPOINT_STALL_PENALTY_EN
        checks++; if (in_latency !== 5'd9) begin errors++; $display("FAIL full_latency_const got=%0d exp=9", in_latency); end
`endif
        tick();
        checks++; if (out_data !== 16'd1) begin errors++; $display("FAIL full_no_overwrite got=%0d exp=1", out_data); end
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 40 && got.size() < 9; cyc++) begin
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL full_drain_ready got=%b exp=%b", in_ready, exp_ready()); end
            if (out_valid === 1'b1) got.push_back(out_data);
            if (in_valid && exp_ready()) begin
                tick();
                in_valid = 1'b0;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++; if (got.size() != 9) begin errors++; $display("FAIL full_drain_count got=%0d exp=9", got.size()); end
        for (int i = 0; i < got.size() && i < 9; i++) begin
            checks++; if (got[i] !== DW'(i + 1)) begin errors++; $display("FAIL full_drain_order idx=%0d got=%0d exp=%0d", i, got[i], i + 1); end
        end
        while (model_q.size() != 0) begin out_ready = 1'b1; tick(); end
        out_ready = 1'b0;
    endtask

    task automatic test_wrap();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            tick();
        end
        out_ready = 1'b1;
`ifndef LATENCY_ENDPOINT_STALL_PENALTY_EN
        checks++; if (in_latency !== 5'd4) begin errors++; $display("FAIL wrap_latency_const got=%0d exp=4", in_latency); end
`endif
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            checks++; if (out_valid !== 1'b1 || out_data !== model_q[0]) begin errors++; $display("FAIL wrap_data v=%b got=%h exp=%h", out_valid, out_data, model_q[0]); end
            checks++; if (in_latency !== LW'(exp_lat(1))) begin errors++; $display("FAIL wrap_latency got=%0d exp=%0d", in_latency, exp_lat(1)); end
            tick();
        end
        checks++; if (in_latency !== 5'd4) begin errors++; $display("FAIL wrap_latency_end got=%0d exp=4", in_latency); end
        in_valid = 1'b0;
        for (int i = 0; i < 10 && model_q.size() != 0; i++) begin
            checks++; if (out_data !== model_q[0]) begin errors++; $display("FAIL wrap_drain got=%h exp=%h", out_data, model_q[0]); end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        checks++; if (in_latency_s !== 5'd31) begin errors++; $display("FAIL sat_latency got=%0d exp=31", in_latency_s); end
        checks++; if (in_latency !== LW'(exp_lat(1))) begin errors++; $display("FAIL sat_base1_latency got=%0d exp=%0d", in_latency, exp_lat(1)); end
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) tick();
        out_ready = 1'b0;
        checks++; if (in_latency_s !== 5'd28) begin errors++; $display("FAIL sat_empty_latency got=%0d exp=28", in_latency_s); end
    endtask

    task automatic test_stall();
        out_ready = 1'b0; in_valid = 1'b1; in_data = DW'($urandom);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
`ifdef LATENCY_ENDPOINT_STALL_PENALTY_EN
        checks++; if (in_latency !== 5'd7) begin errors++; $display("FAIL stall_latency got=%0d exp=7", in_latency); end
`else
        checks++; if (in_latency !== 5'd2) begin errors++; $display("FAIL stall_latency got=%0d exp=2", in_latency); end
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++; if (in_latency !== 5'd1) begin errors++; $display("FAIL stall_pop_latency got=%0d exp=1", in_latency); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = DW'($urandom);
            tick();
        end
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL midrst_hs got=%b%b exp=00", in_ready, out_valid); end
        checks++; if (in_latency !== 5'd31 || in_latency_s !== 5'd31) begin errors++; $display("FAIL midrst_latency got=%0d/%0d exp=31", in_latency, in_latency_s); end
        tick();
        rst = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        checks++; if (in_latency !== 5'd1) begin errors++; $display("FAIL midrst_latency_after got=%0d exp=1", in_latency); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst       = ($urandom_range(63) == 0);
            in_valid  = ($urandom_range(9) < 6);
            out_ready = ($urandom_range(9) < 5);
            in_data   = DW'($urandom);
            #1;
            checks++; if (in_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_ready()); end
            checks++; if (out_valid !== exp_valid()) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid()); end
            if (exp_valid()) begin
                checks++; if (out_data !== model_q[0]) begin errors++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", cyc, out_data, model_q[0]); end
            end
            checks++; if (in_latency !== LW'(exp_lat(1))) begin errors++; $display("FAIL rand_latency cyc=%0d got=%0d exp=%0d", cyc, in_latency, exp_lat(1)); end
            checks++; if (in_latency_s !== LW'(exp_lat(28))) begin errors++; $display("FAIL rand_sat_latency cyc=%0d got=%0d exp=%0d", cyc, in_latency_s, exp_lat(28)); end
            tick();
        end
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full();
        test_wrap();
        test_saturation();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/latency_endpoint_fifo.md
# latency_endpoint_fifo

Receiving end of the switch network's valid/ready/latency protocol. Sits in front of each matching engine and accepts data words from a switch output port. Buffers them in a DEPTH-entry FIFO toward the engine, and reports a latency estimate back upstream. Switches use that estimate to route each word toward the least-loaded engine.

## Interface
- DWIDTH, 16, data word width
- LATENCY_COUNT_WIDTH, 5, width of the reported latency field
- DEPTH, 8, FIFO entries; power of two, ≥2
- BASE_LATENCY, 1, fixed latency contribution of the engine itself
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset; synchronous, active-high
- in_valid  input  1  upstream word valid
- in_data  input  DWIDTH  upstream word
- in_ready  output  1  endpoint can accept a word this cycle
- in_latency  output  LATENCY_COUNT_WIDTH  latency estimate reported to the upstream switch
- out_valid  output  1  FIFO head valid toward engine
- out_data  output  DWIDTH  FIFO head word
- out_ready  input  1  engine accepts head word

## Operation
- Push: occurs when in_valid && in_ready at a rising edge; writes in_data at wr_ptr; wr_ptr advances modulo DEPTH.
- Pop: occurs when out_valid && out_ready at a rising edge; rd_ptr advances modulo DEPTH.
- Occupancy counter `count` is 0..DEPTH. Simultaneous push and pop leaves `count` unchanged.
- Pointers wrap silently. Strict FIFO order is preserved across the wrap.
- in_ready = !rst && (count != DEPTH).
  - Full: no push, even if a pop happens in the same cycle. in_ready does not depend combinationally on out_ready.
- out_valid = !rst && (count != 0). out_data = mem[rd_ptr]. Both are driven from registered state only.
- Empty: no pop. out_data is don't-care while out_valid=0.
- in_latency = saturate(BASE_LATENCY + count [+ stall_cnt, see Configuration]).
  - The sum is computed at LATENCY_COUNT_WIDTH+2 bits.
  - The result clamps to 2^LATENCY_COUNT_WIDTH−1.
  - in_latency is a function of registered state only.
- While rst=1: in_latency = all ones, which steers switches away from this endpoint.
- Reset values, applied at the edge where rst=1:
  - count=0, wr_ptr=0, rd_ptr=0, stall_cnt=0.
  - Memory contents are not reset.
- Outputs while rst=1: in_ready=0, out_valid=0, in_latency=all ones.
- Reset mid-operation: all buffered words are discarded. No word is presented after reset deasserts.
- Inputs are ignored during reset.

## Timing
- Input-to-output latency is 1 cycle. A word pushed at edge k appears on out_data/out_valid after edge k and can be popped at edge k+1.
- Throughput is one word per cycle sustained when out_ready=1.
- in_latency reflects occupancy after the previous edge. A push at edge k raises in_latency in the cycle following edge k.
- First cycle after rst deasserts: in_ready=1, out_valid=0, in_latency=BASE_LATENCY (saturated).
- No combinational path exists from any input to any output except through rst.

## Configuration
- LATENCY_ENDPOINT_STALL_PENALTY_EN defined:
  - Adds a LATENCY_COUNT_WIDTH-bit saturating stall_cnt.
  - stall_cnt increments at each edge with out_valid && !out_ready.
  - stall_cnt clears to 0 at any edge with a pop, or while count=0.
  - in_latency = saturate(BASE_LATENCY + count + stall_cnt). A stalled engine therefore looks slower to the switches.
- LATENCY_ENDPOINT_STALL_PENALTY_EN undefined:
  - stall_cnt logic is absent.
  - in_latency = saturate(BASE_LATENCY + count).

## Test plan
Defaults unless stated: DWIDTH=16, LATENCY_COUNT_WIDTH=5, DEPTH=8, BASE_LATENCY=1, macro undefined.
- Reset: hold rst=1 for 2 cycles with in_valid=1.
  - During reset: in_ready=0, out_valid=0, in_latency=5'b11111.
  - First cycle after reset: in_ready=1, in_latency=5'b00001, nothing buffered.
- Single word: push 16'd255 with out_ready=0.
  - Next cycle: out_valid=1, out_data=16'd255, in_latency=5'b00010.
  - Assert out_ready: word pops, and the following cycle has out_valid=0, in_latency=5'b00001.
- Full: push 16'd1..16'd8 with out_ready=0, then hold in_valid=1 with 16'd9.
  - After the 8th push: in_ready=0, in_latency=5'd9, 16'd9 not accepted.
  - Release out_ready: drains 1..8 in order, then 16'd9 is accepted.
- Concurrent push/pop with wrap: preload 3 words, then stream 20 words with out_ready=1 every cycle.
  - in_latency stays 5'd4 throughout.
  - Output sequence equals input sequence across pointer wrap.
- Saturation: BASE_LATENCY=28, fill all 8 entries → in_latency=5'd31 (not 36 mod 32).
- Macro defined: push one word, hold out_ready=0 for 5 edges → in_latency=5'd7. Pop → in_latency=5'd1.
- Reset mid-operation: with count=5, pulse rst for one cycle → next cycle out_valid=0, in_latency=5'd1.
